// File: rtl/dpram_stream_reader_pkg.sv
// Shared constants for the scratch-RAM stream reader: default RAM geometry and FSM encoding.
// Both the RAM wrapper and the reader import the geometry from here so they cannot drift apart.
package dpram_stream_reader_pkg;

  localparam int DEF_AW = 9;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/dpram_stream_fifo.sv
// Two-entry synchronous FIFO with occupancy count; zero-latency head, push and pop may share a cycle.
// The caller must never push into a full FIFO unless it pops in the same cycle.
module dpram_stream_fifo #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_pdata,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_pdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, a same-cycle push lands on the entry being popped; the pop reads it before the edge.
  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == 2'd0);
  assign o_count = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Sweeps one RAM port over [base, base+len) and streams the bytes out valid/ready with a last marker.
// First beat two cycles after accept, one beat per cycle with ready high; reads stall once two bytes are owed to the sink.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [AW:0]   i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ram_en,
  output logic [AW-1:0] o_ram_addr,
  input  logic [DW-1:0] i_ram_rdata,
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  output logic          o_tlast,
  input  logic          i_tready
);

  localparam logic [AW:0] REM_ONE = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          pend_q, pend_d;
  logic          pend_last_q, pend_last_d;
  logic          done_q, done_d;

  logic          accept, accept_run, issue, pop, credit, head_last, last_beat;
  logic [1:0]    fifo_count;
  logic          fifo_empty;
  logic [DW:0]   fifo_head;
  logic [2:0]    occupancy, room;

  assign accept     = i_start & (state_q == ST_IDLE);
  assign accept_run = accept & (i_len != '0);
  assign pop        = ~fifo_empty & i_tready;
  assign head_last  = fifo_head[DW];
  assign last_beat  = pop & head_last;

  // Bytes already owed to the sink (buffered or in flight) plus this read must fit in two slots.
  assign occupancy = {1'b0, fifo_count} + {2'b00, pend_q} + 3'd1;
  assign room      = 3'd2 + {2'b00, pop};
  assign credit    = (occupancy <= room);
  assign issue     = (state_q == ST_ISSUE) & (rem_q != '0) & credit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_run) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && (rem_q == REM_ONE)) state_d = ST_DRAIN;
      ST_DRAIN: if (last_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    if (accept_run) begin
      addr_d = i_base;
      rem_d  = i_len;
    end else if (issue) begin
      addr_d = addr_q + AW'(1);
      rem_d  = rem_q - REM_ONE;
    end
    pend_d      = issue;
    pend_last_d = issue & (rem_q == REM_ONE);
    done_d      = (accept & (i_len == '0)) | ((state_q == ST_DRAIN) & last_beat);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      done_q      <= done_d;
    end
  end

  // Read data is valid exactly one cycle after issue, so it goes straight into the FIFO with its last tag.
  dpram_stream_fifo #(
    .W (DW + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (pend_q),
    .i_pdata ({pend_last_q, i_ram_rdata}),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    o_busy     = (state_q != ST_IDLE);
    o_done     = done_q;
    o_ram_en   = issue;
    o_ram_addr = addr_q;
    o_tvalid   = ~fifo_empty;
    o_tdata    = fifo_head[DW-1:0];
    o_tlast    = ~fifo_empty & head_last;
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: 512x8 RAM model, command-level reference model, per-cycle compare.
module tb_dpram_stream_reader;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [8:0]  i_base;
  logic [9:0]  i_len;
  logic        o_busy, o_done, o_ram_en, o_tvalid, o_tlast;
  logic [8:0]  o_ram_addr;
  logic [7:0]  ram_rdata, o_tdata;
  logic        i_tready;

  dpram_stream_reader dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base      (i_base),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_ram_en    (o_ram_en),
    .o_ram_addr  (o_ram_addr),
    .i_ram_rdata (ram_rdata),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .o_tlast     (o_tlast),
    .i_tready    (i_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [512];
  always @(posedge clk) if (o_ram_en) ram_rdata <= mem[o_ram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a command owes len bytes mem[(base+i)%512]; reads are tracked as counts.
  bit m_active, m_done_now, m_en_prev;
  int m_base, m_len, m_issued, m_popped;
  bit exp_valid, exp_en, mpop, acc, prev_stall, prev_last, prev_hold;
  int pushed, prev_dat, prev_addr;

  int got_dat[$];
  int got_last[$];
  int got_cyc[$];
  int en_addr[$];
  int acc_cyc, done_cyc;

  always @(negedge clk) begin
    if (i_rst) begin
      m_active = 0; m_done_now = 0; m_en_prev = 0;
      m_issued = 0; m_popped = 0; m_len = 0; m_base = 0;
      prev_stall = 0; prev_hold = 0; prev_addr = 0;
    end else begin
      pushed    = m_issued - (m_en_prev ? 1 : 0);
      exp_valid = m_active && (pushed > m_popped);
      mpop      = exp_valid && i_tready;
      exp_en    = m_active && (m_issued < m_len) &&
                  (m_issued - m_popped + 1 <= 2 + (mpop ? 1 : 0));

      chk("busy", o_busy, m_active);
      chk("done", o_done, m_done_now);
      chk("tvalid", o_tvalid, exp_valid);
      chk("ram_en", o_ram_en, exp_en);
      if (exp_valid) begin
        chk("tdata", o_tdata, mem[(m_base + m_popped) % 512]);
        chk("tlast", o_tlast, (m_popped == m_len - 1));
      end else begin
        chk("tlast_idle", o_tlast, 0);
      end
      if (prev_stall) begin
        chk("stall_tdata", o_tdata, prev_dat);
        chk("stall_tlast", o_tlast, prev_last);
      end
      if (exp_en) chk("ram_addr", o_ram_addr, (m_base + m_issued) % 512);
      else if (prev_hold) chk("ram_addr_hold", o_ram_addr, prev_addr);
      chk("owed_le_2", (m_issued - m_popped + int'(o_ram_en) - int'(o_tvalid && i_tready)) <= 2, 1);

      if (o_tvalid && i_tready) begin
        got_dat.push_back(o_tdata);
        got_last.push_back(o_tlast);
        got_cyc.push_back(cyc);
      end
      if (o_ram_en) en_addr.push_back(o_ram_addr);
      if (o_done) done_cyc = cyc;

      acc        = i_start && !m_active;
      prev_stall = o_tvalid && !i_tready;
      prev_dat   = o_tdata;
      prev_last  = o_tlast;
      prev_hold  = !exp_en && !(acc && i_len != 0);
      prev_addr  = o_ram_addr;
      m_done_now = (acc && i_len == 0) || (mpop && m_popped == m_len - 1);
      m_en_prev  = exp_en;
      if (exp_en) m_issued++;
      if (mpop) begin
        m_popped++;
        if (m_popped == m_len) m_active = 0;
      end
      if (acc) begin
        m_base = i_base; m_len = i_len;
        m_issued = 0; m_popped = 0; m_en_prev = 0;
        m_active = (i_len != 0);
        acc_cyc = cyc + 1;
      end
    end
  end

  int rdy_mode = 0;
  logic [5:0] pat = 6'b101001;
  initial begin
    int k = 0;
    i_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: i_tready = 1'b1;
        1: begin i_tready = pat[k % 6]; k++; end
        default: i_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic clear_rec();
    got_dat.delete(); got_last.delete(); got_cyc.delete(); en_addr.delete();
    done_cyc = -1000; acc_cyc = -2000;
  endtask

  task automatic start_cmd(input int base, input int len);
    @(posedge clk); #1;
    i_start = 1'b1; i_base = 9'(base); i_len = 10'(len);
    @(posedge clk); #1;
    i_start = 1'b0; i_base = 9'($urandom); i_len = 10'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while ((m_active || m_done_now) && n < budget);
    if (m_active || m_done_now) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_timeout: still active after %0d cycles, expected completion", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    int exp_d[4];
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_base = '0; i_len = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    clear_rec();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_ram_en", o_ram_en, 0);
    chk("rst_tvalid", o_tvalid, 0); chk("rst_tlast", o_tlast, 0);
    chk("rst_tdata", o_tdata, 0); chk("rst_ram_addr", o_ram_addr, 0);
    @(posedge clk); #1; i_rst = 1'b0;

    // base 16, len 4, ready high
    rdy_mode = 0; clear_rec();
    start_cmd(16, 4); wait_done(50);
    chk("t1_beats", got_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", got_dat[i], 16 + i);
      chk("t1_last", got_last[i], (i == 3));
      chk("t1_beat_cyc", got_cyc[i] - acc_cyc, 2 + i);
    end
    chk("t1_done_cyc", done_cyc - acc_cyc, 6);

    // wrap-around sweep
    clear_rec();
    start_cmd(510, 4); wait_done(50);
    exp_a = '{510, 511, 0, 1};
    exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    chk("t2_reads", en_addr.size(), 4);
    chk("t2_beats", got_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", en_addr[i], exp_a[i]);
      chk("t2_data", got_dat[i], exp_d[i]);
    end

    // len 6 under toggling ready
    rdy_mode = 1; clear_rec();
    start_cmd(300, 6); wait_done(100);
    chk("t3_beats", got_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_data", got_dat[i], (300 + i) % 256);
    chk("t3_done_after_last", done_cyc - got_cyc[got_cyc.size() - 1], 1);

    // len 0
    rdy_mode = 0; clear_rec();
    start_cmd(77, 0); wait_done(20);
    chk("t4_done_cyc", done_cyc - acc_cyc, 0);
    chk("t4_beats", got_dat.size(), 0);
    chk("t4_reads", en_addr.size(), 0);

    // start re-pulsed while busy
    clear_rec();
    start_cmd(40, 10);
    repeat (2) @(posedge clk);
    #1; i_start = 1'b1; i_base = 9'd100; i_len = 10'd3;
    @(posedge clk); #1; i_start = 1'b0;
    wait_done(100);
    chk("t5_beats", got_dat.size(), 10);
    chk("t5_first", got_dat[0], 40);
    chk("t5_last_data", got_dat[9], 49);
    chk("t5_last_flag", got_last[9], 1);

    // async reset after the second beat
    clear_rec();
    start_cmd(200, 8);
    n = 0;
    while (got_dat.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_two_beats_seen", got_dat.size() >= 2, 1);
    #2; i_rst = 1'b1; #1;
    chk("t6_busy", o_busy, 0); chk("t6_done", o_done, 0); chk("t6_ram_en", o_ram_en, 0);
    chk("t6_tvalid", o_tvalid, 0); chk("t6_tlast", o_tlast, 0);
    chk("t6_tdata", o_tdata, 0); chk("t6_ram_addr", o_ram_addr, 0);
    repeat (2) @(posedge clk);
    #1; i_rst = 1'b0;
    clear_rec();
    start_cmd(0, 2); wait_done(30);
    chk("t6_beats", got_dat.size(), 2);
    chk("t6_b0", got_dat[0], 0); chk("t6_b1", got_dat[1], 1);
    chk("t6_l0", got_last[0], 0); chk("t6_l1", got_last[1], 1);

    // randomized commands over random RAM contents
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 14; t++) begin
      int b, l;
      b = $urandom_range(0, 511);
      l = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 24);
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      clear_rec();
      start_cmd(b, l); wait_done(400);
      chk("rnd_beats", got_dat.size(), l);
    end

    // full-depth sweep
    rdy_mode = 2; clear_rec();
    start_cmd($urandom_range(0, 511), 512); wait_done(4000);
    chk("full_beats", got_dat.size(), 512);
    chk("full_reads", en_addr.size(), 512);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Read-side client for the 512x8 dual-port scratch RAM.
- On command, it sweeps one RAM port over a range of addresses and issues synchronous reads (1-cycle read latency).
- It presents the bytes as a valid/ready byte stream with a last marker.
- Used to dump RAM contents (e.g. preloaded messages or per-core status bytes) towards a UART/emitter, with full backpressure support.

Parameters:
- AW, 9, RAM address width; RAM depth is 2**AW.
- DW, 8, RAM and stream data width.

Ports:
- i_clk  in  1  single clock, shared with the RAM port it drives
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  command strobe; accepted only when o_busy=0
- i_base  in  AW  first RAM address of the sweep
- i_len  in  AW+1  number of bytes, 0..2**AW
- o_busy  out  1  high from command accept until the last beat completes
- o_done  out  1  one-cycle pulse at command completion
- o_ram_en  out  1  RAM port enable; write-enable is tied low externally
- o_ram_addr  out  AW  RAM port address
- i_ram_rdata  in  DW  RAM port read data, valid the cycle after o_ram_en
- o_tdata  out  DW  stream data
- o_tvalid  out  1  stream valid
- o_tlast  out  1  marks the final byte of the command
- i_tready  in  1  stream ready from the sink

Behaviour:
- Reset (async assert, sync release) clears:
  - o_busy, o_done, o_ram_en, o_tvalid, o_tlast = 0
  - o_tdata = 0, o_ram_addr = 0
  - FIFO and pending-read counters emptied.
- Command accept:
  - Occurs at a rising edge where i_start=1 and o_busy=0.
  - i_base and i_len are latched at that edge.
  - i_start while busy is ignored and has no side effects.
- i_len=0: o_busy stays 0 and o_done pulses in the cycle after accept. No RAM read, no beat.
- States:
  - IDLE -> ISSUE on accept with len>0.
  - ISSUE -> DRAIN after the last read is issued.
  - DRAIN -> IDLE on the handshake of the tlast beat; o_done pulses the following cycle.
- Reads:
  - o_ram_en=1 in a cycle when reads remain and credit is available; o_ram_addr = current address.
  - Address increments by 1 per issued read, modulo 2**AW (base 510, len 4 reads 510, 511, 0, 1).
  - o_ram_addr holds its value when no read is issued.
- Return path:
  - Data from a read issued in cycle k is sampled from i_ram_rdata at the end of cycle k+1.
  - It is pushed into a 2-entry output FIFO. No other capture register.
- Credit rule: issue allowed iff fifo_count + pending + 1 <= 2 + pop.
  - pending = reads issued but not yet written into the FIFO (0..1).
  - pop = o_tvalid & i_tready in the same cycle.
  - The FIFO must never overflow; no byte is ever dropped or duplicated.
- Stream:
  - o_tvalid = FIFO not empty; o_tdata = FIFO head.
  - o_tdata and o_tlast are stable while o_tvalid=1 and i_tready=0.
  - o_tlast=1 only on the byte from the final address.
- Latency: accept at edge E0; o_ram_en high in cycle E0..E1; first o_tvalid after E2.
- Throughput: with i_tready held high, 1 beat per cycle sustained; len bytes complete in len+2 cycles after accept.
- Backpressure:
  - i_tready low for any duration stalls issuing once credit is exhausted.
  - At most 2 bytes are buffered.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- o_busy:
  - Rises the cycle after accept.
  - Falls in the same cycle o_done pulses.
  - A new command may be accepted at the edge ending the o_done cycle.
- Reset mid-command: everything is cleared immediately; any in-flight read data is discarded; no o_done.
- i_len = 2**AW reads every location exactly once starting at i_base.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, ISSUE, DRAIN)
  - the default AW/DW values used by both the RAM and this block.
- One natural sub-module: dpram_stream_fifo, a 2-entry synchronous FIFO with count output.
  - Push and pop in the same cycle are allowed.
  - It uses the same async active-high reset.

Test Plan:
- RAM preloaded with addr[7:0]; start base=16, len=4, tready=1 -> bytes 0x10..0x13 on consecutive cycles; tlast on 0x13; first tvalid 2 cycles after accept; o_done one cycle after the last beat.
- base=510, len=4 -> bytes 0xFE, 0xFF, 0x00, 0x01; o_ram_addr sequence 510, 511, 0, 1.
- len=6 with tready toggling 1,0,0,1,0,1... -> all 6 bytes exactly once, in order; o_tdata stable during stalls; FIFO count never exceeds 2; o_ram_en never asserted without credit.
- len=0 -> o_done pulse next cycle; no o_ram_en, no o_tvalid; o_busy stays 0.
- i_start re-pulsed with base=100 mid-command -> ignored; output matches the original command only.
- Assert i_rst asynchronously after the 2nd beat of a len=8 command -> all outputs 0 immediately. A new command base=0, len=2 then yields exactly 0x00, 0x01 with no stale data.
